ahblite_s_port_marb: RTL

AHBLITE_S_PORT_MARB -- requirements
Module: ahblite_s_port_marb

---
 rtl/ahblite_s_port_marb.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ahblite_s_port_marb.sv
// ahblite_s_port_marb: round-robin multi-master arbiter in front of one AHB-Lite slave port.
// Optional locked-burst retention is enabled by defining AHBLITE_S_PORT_MARB_LOCK_EN.
module ahblite_s_port_marb #(
    parameter int AHB_AW  = 32,
    parameter int AHB_DW  = 32,
    parameter int MST_NUM = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             hsel_o,
    output logic [AHB_AW-1:0]                haddr_o,
    output logic                             hwrite_o,
    output logic [1:0]                       htrans_o,
    output logic [2:0]                       hsize_o,
    output logic [2:0]                       hburst_o,
    output logic [3:0]                       hprot_o,
    output logic                             hmastlock_o,
    output logic [AHB_DW-1:0]                hwdata_o,
    output logic                             hready_o,
    input  logic                             hreadyout_i,
    input  logic                             hresp_i,
    input  logic [AHB_DW-1:0]                hrdata_i,
    input  logic [MST_NUM-1:0]               s_req_i,
    output logic [MST_NUM-1:0]               s_grant_o,
    output logic [MST_NUM-1:0]               s_dgrant_o,
    input  logic [MST_NUM-1:0][AHB_AW-1:0]   s_haddr_i,
    input  logic [MST_NUM-1:0]               s_hwrite_i,
    input  logic [MST_NUM-1:0][1:0]          s_htrans_i,
    input  logic [MST_NUM-1:0][2:0]          s_hsize_i,
    input  logic [MST_NUM-1:0][2:0]          s_hburst_i,
    input  logic [MST_NUM-1:0][3:0]          s_hprot_i,
    input  logic [MST_NUM-1:0]               s_hmastlock_i,
    input  logic [MST_NUM-1:0][AHB_DW-1:0]   s_hwdata_i,
    output logic                             s_hready_o,
    output logic                             s_hresp_o,
    output logic [AHB_DW-1:0]                s_hrdata_o
);
    localparam int MW = $clog2(MST_NUM);
    typedef enum logic [1:0] {IDLE, ARB, ACCESS} state_e;
    state_e           state_q, state_d;
    logic [MW-1:0]    cur_q, cur_d, dmst_q, dmst_d, rr_mst;
    logic             dval_q, dval_d;
    logic [4:0]       beat_q, beat_d, limit;
    logic             grant, accept, incr_end, burst_end, lock;

    assign grant       = state_q == ACCESS;
    assign hsel_o      = state_q != IDLE;
    assign haddr_o     = grant ? s_haddr_i[cur_q] : '0;
    assign hwrite_o    = grant ? s_hwrite_i[cur_q] : 1'b0;
    assign htrans_o    = grant ? s_htrans_i[cur_q] : 2'b00;
    assign hsize_o     = grant ? s_hsize_i[cur_q] : '0;
    assign hburst_o    = grant ? s_hburst_i[cur_q] : '0;
    assign hprot_o     = grant ? s_hprot_i[cur_q] : '0;
    assign s_grant_o   = grant ? MST_NUM'(1) << cur_q : '0;
    assign s_dgrant_o  = dval_q ? MST_NUM'(1) << dmst_q : '0;
    assign hwdata_o    = dval_q ? s_hwdata_i[dmst_q] : '0;
    assign hready_o    = hreadyout_i;
    assign s_hready_o  = hreadyout_i;
    assign s_hresp_o   = hresp_i;
    assign s_hrdata_o  = hrdata_i;

`ifdef AHBLITE_S_PORT_MARB_LOCK_EN
    assign lock        = s_hmastlock_i[cur_q];
    assign hmastlock_o = grant & lock;
`else
    logic unused_mastlock;
    assign unused_mastlock = |s_hmastlock_i;
    assign lock        = 1'b0;
    assign hmastlock_o = 1'b0;
`endif

    assign accept    = grant && htrans_o[1] && hreadyout_i;
    assign limit     = hburst_o[2:1] == 2'b00 ? 5'd1 : hburst_o[2:1] == 2'b01 ? 5'd4 :
                       hburst_o[2:1] == 2'b10 ? 5'd8 : 5'd16;
    assign incr_end  = htrans_o == 2'b00 || (htrans_o == 2'b10 && beat_q != 5'd0);
    // The second ERROR cycle ends the burst whatever the beat count.
    assign burst_end = grant && hreadyout_i &&
                       (hresp_i || (hburst_o == 3'b001 ? incr_end : accept && beat_q + 5'd1 == limit));

    // Lowest requester above cur_q wins; otherwise wrap to the lowest at or below it.
    always_comb begin
        rr_mst = cur_q;
        for (int i = MST_NUM - 1; i >= 0; i--)
            if (s_req_i[i] && i <= int'(cur_q)) rr_mst = MW'(i);
        for (int i = MST_NUM - 1; i >= 0; i--)
            if (s_req_i[i] && i > int'(cur_q)) rr_mst = MW'(i);
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        beat_d  = beat_q;
        dval_d  = hreadyout_i ? accept : dval_q;
        dmst_d  = accept ? cur_q : dmst_q;
        unique case (state_q)
            IDLE:    state_d = |s_req_i ? ARB : IDLE;
            ARB:     begin
                state_d = ACCESS;
                cur_d   = rr_mst;
            end
            ACCESS:  begin
                beat_d  = burst_end ? 5'd0 : beat_q + 5'(accept);
                state_d = !burst_end ? ACCESS : lock ? ACCESS : |s_req_i ? ARB : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= MW'(MST_NUM - 1);
            beat_q  <= '0;
            dval_q  <= 1'b0;
            dmst_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            beat_q  <= beat_d;
            dval_q  <= dval_d;
            dmst_q  <= dmst_d;
        end
    end
endmodule
